dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave for the core's LSU request/grant/rvalid data interface; it is the responder end of that interface.
- Accepts word-indexed requests with 4-bit byte enables, grants after a configurable number of wait states, and performs byte-lane writes into an internal RAM.
- Returns the full 32-bit word one cycle after grant; the LSU side performs byte/halfword extraction.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM.
- WAIT_STATES, 0, cycles a request is held before gnt; legal range 0..15.
- ERR_RDATA, 32'h0000_0000, rdata returned for an out-of-range read.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  1  request valid.
- data_addr_i  in  32  word index, not a byte address; only [$clog2(DEPTH_WORDS)-1:0] are used for indexing, and the upper bits are checked for range.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; lane k = wdata[8k+7:8k].
- data_wdata_i  in  32  write data, already lane-aligned.
- data_gnt_o  out  1  request accepted this cycle (combinational from state, counter and req).
- data_rvalid_o  out  1  response valid, registered.
- data_rdata_o  out  32  read word, registered.
- data_err_o  out  1  out-of-range access flag, valid with rvalid.

Behaviour:
- Reset: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, FSM=IDLE, wait counter=0.
- RAM contents are not reset; the RAM is not written while rst_n=0.
- FSM states:
  - IDLE: no request pending.
  - WAIT: counting wait states.
  - RESP: rvalid cycle.
- IDLE:
  - req=1 and WAIT_STATES=0: gnt=1 this cycle; go to RESP.
  - req=1 and WAIT_STATES>0: load counter=WAIT_STATES-1; go to WAIT, gnt=0.
- WAIT:
  - req=1 and counter=0: gnt=1; go to RESP.
  - req=1 and counter>0: decrement.
  - req=0: abort and return to IDLE with no memory side effect and no rvalid.
- Timing summary: gnt falls in cycle WAIT_STATES+1 of a continuously held req; rvalid is high exactly one cycle after the gnt cycle, for exactly one cycle.
- At the gnt clock edge:
  - Write: for each k with be[k]=1, mem[addr][8k+7:8k] <= wdata[8k+7:8k]. Lanes with be[k]=0 are unchanged. be=0000 is a legal no-op write.
  - Read: rdata_o <= mem[addr], the full word regardless of be.
  - Write response: rdata_o <= 0 (rvalid still pulses for writes).
- RESP:
  - rvalid=1.
  - req=1 and WAIT_STATES=0: grant again in the same cycle (back-to-back, one transaction per cycle); stay in RESP.
  - req=1 and WAIT_STATES>0: load the counter and go to WAIT.
  - Otherwise go to IDLE.
- Read-after-write: a read granted the cycle after a write to the same word returns the newly written bytes (the RAM write completes at the earlier gnt edge).
- Out of range (data_addr_i >= DEPTH_WORDS):
  - The access is still granted.
  - Writes are dropped.
  - Reads return ERR_RDATA.
  - data_err_o=1 with that rvalid; data_err_o=0 on all in-range responses.
- Inputs are sampled only in the gnt cycle; changes to addr/we/be/wdata during WAIT are permitted, and the values present at gnt win.
- Reset asserted mid-transaction (WAIT or RESP): outputs clear immediately, the pending request is discarded, no rvalid is issued after reset release, and no partial write occurs unless the gnt edge preceded reset.
- gnt is never asserted when req=0. rvalid is never asserted without a preceding gnt.

Decomposition:
- Shared package riscv_defines holds:
  - typedef enum logic [1:0] dmem_state_e {DMEM_IDLE, DMEM_WAIT, DMEM_RESP};
  - localparams BE_NONE=4'b0000 and BE_WORD=4'b1111.
- One sub-module: dmem_bank, a DEPTH_WORDS x 32 RAM with 4 byte-lane write enables and a synchronous read port. It contains no control logic, so the bank can later be swapped for a technology macro.

Test Plan:
- Reset, then WAIT_STATES=0, write addr=5, be=1111, wdata=32'hA5A5_1234 -> gnt in cycle 1, rvalid in cycle 2 with rdata=0; read addr=5 -> rdata=32'hA5A5_1234, err=0.
- Byte-lane write: preload word 7 = 32'h1122_3344, write be=0100, wdata=32'h00EE_0000 -> read back 32'h11EE_3344; write be=1100, wdata=32'hBEEF_0000 -> read back 32'hBEEF_3344.
- WAIT_STATES=3, read held 4 cycles -> gnt only in cycle 4, rvalid in cycle 5. Same setup with req dropped in cycle 2 -> no gnt, no rvalid, memory unchanged.
- Back-to-back WAIT_STATES=0: write addr 9 = 32'hCAFE_F00D followed next cycle by read addr 9 -> gnt on both cycles, rvalids on consecutive cycles, second rdata=32'hCAFE_F00D.
- Out of range, DEPTH_WORDS=1024: write addr=1024 then read addr=1024 -> both granted, err=1 on both rvalids, read rdata=ERR_RDATA. Word 0 remains unchanged (no aliasing).
- Reset pulse during WAIT (WAIT_STATES=2) of a write to addr 3 -> gnt, rvalid and rdata are 0 after reset, no rvalid after release, and word 3 holds its prior value.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the LSU data-interface responder.
//   dmem_state_e : handshake FSM states (idle / counting wait states / rvalid).
//   BE_NONE      : byte-enable pattern that writes no lane.
//   BE_WORD      : byte-enable pattern covering the full 32-bit word.
package riscv_defines;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 single-port RAM with per-byte write enables and a
// synchronous read port. Pure storage with no control logic, so it can be
// replaced by a technology macro with the same behaviour.
//   clk   : rising-edge clock
//   addr  : word index
//   we    : per-lane write enables, lane k = wdata[8k+7:8k]
//   wdata : lane-aligned write data
//   re    : read enable; rdata updates only when set
//   rdata : registered read word
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset branch; resetting a RAM turns it into
    // flops and prevents mapping onto a memory macro.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the LSU req/gnt/rvalid interface. Grants after
// WAIT_STATES cycles of held request, performs byte-lane writes, and returns
// the full word (or 0 for writes) one cycle after grant.
//   clk, rst_n     : clock, asynchronous active-low reset
//   data_req_i     : request valid
//   data_addr_i    : word index; bits above the RAM index are range-checked
//   data_we_i      : 1 = write, 0 = read
//   data_be_i      : byte enables
//   data_wdata_i   : lane-aligned write data
//   data_gnt_o     : request accepted this cycle (combinational)
//   data_rvalid_o  : response valid, one cycle after grant
//   data_rdata_o   : read word (0 for write responses, ERR_RDATA out of range)
//   data_err_o     : out-of-range access, valid with rvalid
module dmem_responder
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_raw;
    logic        gnt;
    logic        in_range;
    logic        rvalid_q;
    logic        err_q;
    logic        read_q;
    logic [3:0]  bank_we;
    logic        bank_re;
    logic [31:0] bank_rdata;

    assign in_range = (data_addr_i < 32'(DEPTH_WORDS));

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        unique case (state_q)
            DMEM_IDLE, DMEM_RESP: begin
                if (data_req_i) begin
                    if (WAIT_STATES == 0) begin
                        gnt_raw = 1'b1;
                        state_d = DMEM_RESP;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = DMEM_WAIT;
                    end
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (!data_req_i) begin
                    state_d = DMEM_IDLE;
                end else if (cnt_q == 4'd0) begin
                    gnt_raw = 1'b1;
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Reset forces IDLE, where a zero-wait request would otherwise grant;
    // gating keeps gnt low and the RAM untouched while reset is held.
    assign gnt = gnt_raw & rst_n;

    // NOTE: state uses non-blocking assignments so all flops update from
    // the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            err_q    <= gnt & ~in_range;
            read_q   <= gnt & ~data_we_i;
        end
    end

    assign bank_we = (gnt && data_we_i && in_range) ? (data_be_i & BE_WORD) : BE_NONE;
    assign bank_re = gnt & ~data_we_i & in_range;

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .addr (data_addr_i[AW-1:0]),
        .we   (bank_we),
        .wdata(data_wdata_i),
        .re   (bank_re),
        .rdata(bank_rdata)
    );

    // The bank's read register carries no reset, so the response word is
    // qualified by the reset flops: 0 outside a read response.
    always_comb begin
        data_rdata_o = 32'h0000_0000;
        if (rvalid_q && read_q) begin
            data_rdata_o = err_q ? ERR_RDATA : bank_rdata;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    // Instance 0: WAIT_STATES=0, ERR_RDATA=DEAD_BEEF; 1: WAIT_STATES=3; 2: WAIT_STATES=2
    localparam logic [31:0] ERR0 = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n  [3];
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int n_total = 0;
    int n_bad   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .ERR_RDATA(ERR0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .data_req_i(req[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .data_req_i(req[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .data_req_i(req[2]), .data_addr_i(addr[2]),
        .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
        .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
        .data_err_o(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction: raise req after a rising edge, hold it until
    // gnt (bounded), then check gnt cycle, rvalid timing, rdata and err.
    task automatic do_xact(input int u, input string tag, input logic w,
                           input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input int exp_cyc,
                           input logic [31:0] exp_rd, input logic exp_err);
        int   cyc;
        logic got;
        logic pre_rv;
        cyc    = 0;
        got    = 1'b0;
        pre_rv = 1'b0;
        @(posedge clk); #1;
        req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = d;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            pre_rv = pre_rv | rvalid[u];
            if (gnt[u]) got = 1'b1;
            @(posedge clk); #1;
        end
        req[u] = 1'b0;
        if (!got) check({tag, "_gnt_timeout"}, 32'(got), 32'd1);
        check({tag, "_gnt_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_rvalid_before_gnt"}, 32'(pre_rv), 32'd0);
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(rvalid[u]), 32'd1);
        check({tag, "_rdata"}, rdata[u], exp_rd);
        check({tag, "_err"}, 32'(err[u]), 32'(exp_err));
        @(negedge clk);
        check({tag, "_rvalid_one_cycle"}, 32'(rvalid[u]), 32'd0);
    endtask

    initial begin
        logic any_bad;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = '0; be[i] = '0; wdata[i] = '0;
        end
        // Zero-wait request held during reset must not be granted
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd5; be[0] = 4'hF; wdata[0] = 32'h1357_9BDF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt[0]), 32'd0);
        check("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Basic write/read, zero wait states
        do_xact(0, "wr5", 1'b1, 32'd5, 4'hF, 32'hA5A5_1234, 1, 32'h0, 1'b0);
        do_xact(0, "rd5", 1'b0, 32'd5, 4'h0, 32'h0, 1, 32'hA5A5_1234, 1'b0);

        // Byte-lane writes
        do_xact(0, "wr7", 1'b1, 32'd7, 4'hF, 32'h1122_3344, 1, 32'h0, 1'b0);
        do_xact(0, "wr7_b2", 1'b1, 32'd7, 4'b0100, 32'h00EE_0000, 1, 32'h0, 1'b0);
        do_xact(0, "rd7_a", 1'b0, 32'd7, 4'hF, 32'h0, 1, 32'h11EE_3344, 1'b0);
        do_xact(0, "wr7_b32", 1'b1, 32'd7, 4'b1100, 32'hBEEF_0000, 1, 32'h0, 1'b0);
        do_xact(0, "rd7_b", 1'b0, 32'd7, 4'h1, 32'h0, 1, 32'hBEEF_3344, 1'b0);
        do_xact(0, "wr7_none", 1'b1, 32'd7, 4'b0000, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
        do_xact(0, "rd7_c", 1'b0, 32'd7, 4'h0, 32'h0, 1, 32'hBEEF_3344, 1'b0);

        // Back-to-back: write 9 then read 9 on the next cycle
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd9; be[0] = 4'hF; wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        check("b2b_gnt1", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        we[0] = 1'b0; wdata[0] = 32'h0;
        @(negedge clk);
        check("b2b_gnt2", 32'(gnt[0]), 32'd1);
        check("b2b_rvalid1", 32'(rvalid[0]), 32'd1);
        check("b2b_rdata1", rdata[0], 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("b2b_gnt_off", 32'(gnt[0]), 32'd0);
        check("b2b_rvalid2", 32'(rvalid[0]), 32'd1);
        check("b2b_rdata2", rdata[0], 32'hCAFE_F00D);
        @(negedge clk);
        check("b2b_rvalid_end", 32'(rvalid[0]), 32'd0);

        // Out of range: no aliasing onto word 0
        do_xact(0, "wr0", 1'b1, 32'd0, 4'hF, 32'h0123_4567, 1, 32'h0, 1'b0);
        do_xact(0, "wr_oor", 1'b1, 32'd1024, 4'hF, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
        do_xact(0, "rd_oor", 1'b0, 32'd1024, 4'hF, 32'h0, 1, ERR0, 1'b1);
        do_xact(0, "rd_oor_hi", 1'b0, 32'h8000_0000, 4'hF, 32'h0, 1, ERR0, 1'b1);
        do_xact(0, "rd0", 1'b0, 32'd0, 4'hF, 32'h0, 1, 32'h0123_4567, 1'b0);

        // Reset during RESP: write already happened at the gnt edge
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd11; be[0] = 4'hF; wdata[0] = 32'h5555_AAAA;
        @(negedge clk);
        check("rresp_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("rresp_rvalid_pre", 32'(rvalid[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        check("rresp_rvalid_rst", 32'(rvalid[0]), 32'd0);
        check("rresp_err_rst", 32'(err[0]), 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        do_xact(0, "rd11", 1'b0, 32'd11, 4'hF, 32'h0, 1, 32'h5555_AAAA, 1'b0);

        // WAIT_STATES=3: timing and abort
        do_xact(1, "ws3_wr20", 1'b1, 32'd20, 4'hF, 32'h1111_0000, 4, 32'h0, 1'b0);
        do_xact(1, "ws3_rd20", 1'b0, 32'd20, 4'hF, 32'h0, 4, 32'h1111_0000, 1'b0);
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd20; be[1] = 4'hF; wdata[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        check("abort_gnt_c1", 32'(gnt[1]), 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        any_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_bad = any_bad | gnt[1] | rvalid[1];
        end
        check("abort_no_gnt_rvalid", 32'(any_bad), 32'd0);
        do_xact(1, "abort_rd20", 1'b0, 32'd20, 4'hF, 32'h0, 4, 32'h1111_0000, 1'b0);

        // WAIT_STATES=2: reset pulse during WAIT of a write
        do_xact(2, "ws2_wr3", 1'b1, 32'd3, 4'hF, 32'h3333_3333, 3, 32'h0, 1'b0);
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'd3; be[2] = 4'hF; wdata[2] = 32'hDEAD_0000;
        @(negedge clk);
        check("rwait_gnt_c1", 32'(gnt[2]), 32'd0);
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        check("rwait_gnt_rst", 32'(gnt[2]), 32'd0);
        check("rwait_rvalid_rst", 32'(rvalid[2]), 32'd0);
        check("rwait_rdata_rst", rdata[2], 32'h0);
        @(negedge clk);
        req[2] = 1'b0;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        any_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_bad = any_bad | rvalid[2];
        end
        check("rwait_no_rvalid_after", 32'(any_bad), 32'd0);
        do_xact(2, "rwait_rd3", 1'b0, 32'd3, 4'hF, 32'h0, 3, 32'h3333_3333, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
